// File: rtl/rca_slice_sequencer.sv
// Digit-serial adder controller: computes x+y+ci one SLICE-bit digit per cycle
// through a single external ripple-carry adder attached on the slice_* ports.
module rca_slice_sequencer #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             co,
    output logic [SLICE-1:0] slice_x,
    output logic [SLICE-1:0] slice_y,
    output logic             slice_ci,
    input  logic [SLICE-1:0] slice_z,
    input  logic             slice_co
);
    localparam int NSLICES = WIDTH / SLICE;
    localparam int IDXW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] xr_reg, yr_reg;
    logic [IDXW-1:0]  idx_reg;
    logic             carry_reg, co_reg, busy_reg, done_reg;
    logic             accept, last_step, running;

    assign running = (state_reg == RUN);

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        last_step  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (idx_reg == LAST_IDX) begin
                    last_step  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // A start seen in DONE chains straight into the next addition.
                accept     = start;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == RUN);
            done_reg  <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xr_reg    <= '0;
            yr_reg    <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            co_reg    <= 1'b0;
        end else if (accept) begin
            xr_reg    <= x;
            yr_reg    <= y;
            idx_reg   <= '0;
            carry_reg <= ci;
            co_reg    <= 1'b0;
        end else if (running) begin
            carry_reg <= slice_co;
            // idx parks on the last digit rather than wrapping.
            if (!last_step) idx_reg <= idx_reg + 1'b1;
            if (last_step)  co_reg  <= slice_co;
        end
    end

    // One digit register per result slice; only the digit under idx is written.
    generate
        for (genvar gi = 0; gi < NSLICES; gi++) begin : g_digit
            logic [SLICE-1:0] dig_reg;
            always_ff @(posedge clk) begin
                if (rst || accept) begin
                    dig_reg <= '0;
                end else if (running && idx_reg == IDXW'(gi)) begin
                    dig_reg <= slice_z;
                end
            end
            assign z[gi*SLICE +: SLICE] = dig_reg;
        end
    endgenerate

    assign slice_x  = running ? xr_reg[idx_reg*SLICE +: SLICE] : '0;
    assign slice_y  = running ? yr_reg[idx_reg*SLICE +: SLICE] : '0;
    assign slice_ci = running ? carry_reg : 1'b0;

    assign busy = busy_reg;
    assign done = done_reg;
    assign co   = co_reg;
endmodule

// File: tb/tb_rca_slice_sequencer.sv
// Bench for rca_slice_sequencer: 4-bit adder on the slice ports, results checked
// against a whole-word arithmetic reference.
module tb_rca_slice_sequencer;
    localparam int WIDTH = 16;
    localparam int SLICE = 4;

    logic              clk = 1'b0;
    logic              rst, start, ci;
    logic [WIDTH-1:0]  x, y;
    logic              busy, done, co, slice_ci, slice_co;
    logic [WIDTH-1:0]  z;
    logic [SLICE-1:0]  slice_x, slice_y, slice_z;

    int tests = 0;
    int fails = 0;

    rca_slice_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .ci(ci),
        .busy(busy), .done(done), .z(z), .co(co),
        .slice_x(slice_x), .slice_y(slice_y), .slice_ci(slice_ci),
        .slice_z(slice_z), .slice_co(slice_co)
    );

    // The attached 4-bit ripple-carry adder.
    assign {slice_co, slice_z} = 5'(slice_x) + 5'(slice_y) + 5'(slice_ci);

    always #5 clk = ~clk;

    function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic c);
        return {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c);
    endfunction

    // Issues one start and waits (bounded) for done; caller is at a negedge.
    task automatic do_add(input logic [WIDTH-1:0] ax, input logic [WIDTH-1:0] ay, input logic aci,
                          output logic [WIDTH-1:0] oz, output logic oco, output int nbusy, output int lat);
        x = ax; y = ay; ci = aci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0;
        lat   = 1;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            lat++;
        end
        oz  = z;
        oco = co;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; x = 16'hA5C3; y = 16'h3C5A; ci = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({busy, done, z, co} !== 19'd0) begin
            fails++;
            $display("FAIL reset_outputs got busy=%b done=%b z=%h co=%b exp all 0", busy, done, z, co);
        end
        tests++;
        if ({slice_x, slice_y, slice_ci} !== 9'd0) begin
            fails++;
            $display("FAIL reset_slices got x=%h y=%h ci=%b exp 0", slice_x, slice_y, slice_ci);
        end
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_start_collision got busy=%b exp 0", busy);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL rst_start_dropped got busy=%b done=%b exp 0 0", busy, done);
        end
        $display("[TB] reset checks done");
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] tx [4] = '{16'd3752, 16'hFFFF, 16'hFFFF, 16'h0000};
        logic [WIDTH-1:0] ty [4] = '{16'd21007, 16'h0001, 16'h0000, 16'h0000};
        logic             tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [WIDTH-1:0] oz;
        logic             oco;
        logic [WIDTH:0]   exp_s;
        int               nb, lat;
        for (int i = 0; i < 4; i++) begin
            exp_s = ref_sum(tx[i], ty[i], tc[i]);
            do_add(tx[i], ty[i], tc[i], oz, oco, nb, lat);
            $display("[TB] directed %h+%h+%b -> z=%h co=%b busy=%0d lat=%0d", tx[i], ty[i], tc[i], oz, oco, nb, lat);
            tests++;
            if ({oco, oz} !== exp_s) begin
                fails++;
                $display("FAIL directed_sum[%0d] got %h exp %h", i, {oco, oz}, exp_s);
            end
            tests++;
            if (nb != 4 || lat != 5) begin
                fails++;
                $display("FAIL directed_timing[%0d] got busy=%0d lat=%0d exp 4 5", i, nb, lat);
            end
            @(negedge clk);
            tests++;
            if (done !== 1'b0 || busy !== 1'b0 || {co, z} !== exp_s || slice_x !== 4'd0) begin
                fails++;
                $display("FAIL directed_hold[%0d] got done=%b busy=%b z=%h co=%b sx=%h exp 0 0 %h 0",
                         i, done, busy, z, co, slice_x, exp_s);
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ax, ay, oz;
        logic             ac, oco;
        logic [WIDTH:0]   exp_s;
        int               nb, lat;
        for (int i = 0; i < 25; i++) begin
            ax = WIDTH'($urandom);
            ay = WIDTH'($urandom);
            ac = 1'($urandom);
            exp_s = ref_sum(ax, ay, ac);
            do_add(ax, ay, ac, oz, oco, nb, lat);
            $display("[TB] random %h+%h+%b -> z=%h co=%b", ax, ay, ac, oz, oco);
            tests++;
            if ({oco, oz} !== exp_s || nb != 4 || lat != 5) begin
                fails++;
                $display("FAIL random[%0d] got %h busy=%0d lat=%0d exp %h 4 5", i, {oco, oz}, nb, lat, exp_s);
            end
            if ((i % 3) == 0) @(negedge clk);
        end
    endtask

    task automatic test_start_in_run();
        logic [WIDTH:0] exp_s;
        int             nb, lat;
        exp_s = ref_sum(16'h8421, 16'h7BDE, 1'b1);
        x = 16'h8421; y = 16'h7BDE; ci = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) nb++;
            if (lat == 2) begin
                start = 1'b1; x = 16'h1111; y = 16'h2222; ci = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        $display("[TB] start_in_run -> z=%h co=%b busy=%0d lat=%0d", z, co, nb, lat);
        tests++;
        if ({co, z} !== exp_s) begin
            fails++;
            $display("FAIL start_in_run_sum got %h exp %h", {co, z}, exp_s);
        end
        tests++;
        if (nb != 4 || lat != 5) begin
            fails++;
            $display("FAIL start_in_run_timing got busy=%0d lat=%0d exp 4 5", nb, lat);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL start_in_run_idle got busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [WIDTH-1:0] oz;
        logic             oco;
        logic [WIDTH:0]   exp_s;
        int               nb, lat, pulses;
        x = 16'h1234; y = 16'h1111; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset_mid_run -> busy=%b done=%b z=%h co=%b", busy, done, z, co);
        tests++;
        if ({busy, done, z, co} !== 19'd0) begin
            fails++;
            $display("FAIL reset_mid_run got busy=%b done=%b z=%h co=%b exp all 0", busy, done, z, co);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1 || busy === 1'b1) pulses++;
            @(negedge clk);
        end
        tests++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL reset_mid_run_quiet got %0d active cycles exp 0", pulses);
        end
        exp_s = ref_sum(16'hBEEF, 16'h4111, 1'b1);
        do_add(16'hBEEF, 16'h4111, 1'b1, oz, oco, nb, lat);
        tests++;
        if ({oco, oz} !== exp_s || nb != 4 || lat != 5) begin
            fails++;
            $display("FAIL reset_mid_run_fresh got %h busy=%0d lat=%0d exp %h 4 5", {oco, oz}, nb, lat, exp_s);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] bx [4], by [4];
        logic             bc [4];
        logic [WIDTH:0]   exp_s;
        int               n, cyc, last;
        for (int i = 0; i < 4; i++) begin
            bx[i] = WIDTH'($urandom);
            by[i] = WIDTH'($urandom);
            bc[i] = 1'($urandom);
        end
        bx[1] = 16'hFFFF; by[1] = 16'h0001; bc[1] = 1'b0;
        x = bx[0]; y = by[0]; ci = bc[0]; start = 1'b1;
        n = 0; cyc = 0; last = 0;
        while (n < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                exp_s = ref_sum(bx[n], by[n], bc[n]);
                $display("[TB] back_to_back op%0d %h+%h+%b -> z=%h co=%b at cycle %0d",
                         n, bx[n], by[n], bc[n], z, co, cyc);
                tests++;
                if ({co, z} !== exp_s) begin
                    fails++;
                    $display("FAIL back_to_back_sum[%0d] got %h exp %h", n, {co, z}, exp_s);
                end
                tests++;
                if (cyc - last != 5) begin
                    fails++;
                    $display("FAIL back_to_back_interval[%0d] got %0d exp 5", n, cyc - last);
                end
                last = cyc;
                n++;
                if (n < 4) begin
                    x = bx[n]; y = by[n]; ci = bc[n];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        tests++;
        if (n != 4) begin
            fails++;
            $display("FAIL back_to_back_timeout got %0d results exp 4", n);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; x = '0; y = '0; ci = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_start_in_run();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
